std_divmod_pipe: RTL and testbench

- Parametrised sequential restoring divider that produces quotient and remainder together from one operation.
- Supports unsigned or signed (truncating) division, selected at elaboration.
- Reports divide-by-zero and signed-overflow conditions.
- Sits among the multi-cycle arithmetic primitives and is driven by the standard go/done handshake used by compiled control.

---
 rtl/std_divmod_pipe.sv | 122 ++++++++++++
 tb/tb_std_divmod_pipe.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_divmod_pipe.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first, with
// quotient/remainder produced together and divide-by-zero / signed-overflow flags.
module std_divmod_pipe #(
    parameter int width     = 32,
    parameter bit is_signed = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [width-1:0] left,
    input  logic [width-1:0] right,
    output logic [width-1:0] out_quotient,
    output logic [width-1:0] out_remainder,
    output logic             done,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    state_t state, state_next;

    // dvd holds the unconsumed dividend bits; quotient bits fill in from the bottom
    logic [width-1:0] dvd, dvs, left_raw, rem;
    logic [CW-1:0]    count;
    logic             sign_q, sign_r, dbz, ovf;

    logic             left_neg, right_neg, ge;
    logic [width-1:0] left_mag, right_mag, int_min, diff;
    logic [width:0]   trial;

    always_comb begin
        int_min          = '0;
        int_min[width-1] = 1'b1;
        left_neg         = is_signed && left[width-1];
        right_neg        = is_signed && right[width-1];
        left_mag         = left_neg ? -left : left;
        right_mag        = right_neg ? -right : right;
        trial            = {rem, dvd[width-1]};
        ge               = trial >= {1'b0, dvs};
        // when ge holds the difference is below dvs, so width bits suffice
        diff             = trial[width-1:0] - dvs;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = (right == '0) ? FINISH : RUN;
            RUN: begin
                if (!go)                    state_next = IDLE;
                else if (count == CW'(1))   state_next = FINISH;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd           <= '0;
            dvs           <= '0;
            left_raw      <= '0;
            rem           <= '0;
            count         <= '0;
            sign_q        <= 1'b0;
            sign_r        <= 1'b0;
            dbz           <= 1'b0;
            ovf           <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            done          <= 1'b0;
            div_by_zero   <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            case (state)
                IDLE: begin
                    if (go) begin
                        dvd      <= left_mag;
                        dvs      <= right_mag;
                        left_raw <= left;
                        sign_q   <= left_neg ^ right_neg;
                        sign_r   <= left_neg;
                        rem      <= '0;
                        count    <= CW'(width);
                        dbz      <= (right == '0);
                        ovf      <= is_signed && (left == int_min) && (right == '1);
                    end
                end
                RUN: begin
                    if (go) begin
                        rem   <= ge ? diff : trial[width-1:0];
                        dvd   <= {dvd[width-2:0], ge};
                        count <= count - CW'(1);
                    end
                end
                FINISH: begin
                    done <= 1'b1;
                    if (dbz) begin
                        out_quotient  <= '1;
                        out_remainder <= left_raw;
                        div_by_zero   <= 1'b1;
                    end else begin
                        out_quotient  <= sign_q ? -dvd : dvd;
                        out_remainder <= sign_r ? -rem : rem;
                        overflow      <= ovf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_std_divmod_pipe.sv
// Bench for std_divmod_pipe: three instances (8-bit unsigned, 8-bit signed,
// 32-bit unsigned) checked every cycle against an arithmetic reference model.
module tb_std_divmod_pipe;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    int widths[3] = '{8, 8, 32};
    bit sgn[3]    = '{1'b0, 1'b1, 1'b0};

    logic [2:0]  go_v;
    logic [2:0]  done_v, dz_v, ov_v;
    logic [31:0] l_a[3];
    logic [31:0] r_a[3];
    logic [7:0]  q0, rm0, q1, rm1;
    logic [31:0] q2, rm2;
    logic [31:0] q_a[3];
    logic [31:0] rm_a[3];

    always_comb begin
        q_a[0]  = {24'b0, q0};
        rm_a[0] = {24'b0, rm0};
        q_a[1]  = {24'b0, q1};
        rm_a[1] = {24'b0, rm1};
        q_a[2]  = q2;
        rm_a[2] = rm2;
    end

    std_divmod_pipe #(.width(8), .is_signed(1'b0)) u_u8 (
        .clk(clk), .reset(reset), .go(go_v[0]),
        .left(l_a[0][7:0]), .right(r_a[0][7:0]),
        .out_quotient(q0), .out_remainder(rm0),
        .done(done_v[0]), .div_by_zero(dz_v[0]), .overflow(ov_v[0])
    );

    std_divmod_pipe #(.width(8), .is_signed(1'b1)) u_s8 (
        .clk(clk), .reset(reset), .go(go_v[1]),
        .left(l_a[1][7:0]), .right(r_a[1][7:0]),
        .out_quotient(q1), .out_remainder(rm1),
        .done(done_v[1]), .div_by_zero(dz_v[1]), .overflow(ov_v[1])
    );

    std_divmod_pipe #(.width(32), .is_signed(1'b0)) u_u32 (
        .clk(clk), .reset(reset), .go(go_v[2]),
        .left(l_a[2]), .right(r_a[2]),
        .out_quotient(q2), .out_remainder(rm2),
        .done(done_v[2]), .div_by_zero(dz_v[2]), .overflow(ov_v[2])
    );

    logic [31:0] exp_q[3], exp_rm[3], exp_l[3], exp_r[3];
    logic        exp_dz[3], exp_ov[3];
    int          exp_cyc[3];
    bit          pend[3];
    logic [31:0] last_q[3], last_rm[3];
    logic        last_dz[3], last_ov[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] mask_of(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    // Reference: plain integer division with C-style truncation for signed mode.
    function automatic void model(input int w, input bit s, input logic [31:0] l, input logic [31:0] r,
                                  output logic [31:0] q, output logic [31:0] rm,
                                  output logic dz, output logic ov);
        longint m, lu, ru, lv, rv, half, qq, rr;
        m    = longint'(mask_of(w));
        lu   = longint'({32'b0, l}) & m;
        ru   = longint'({32'b0, r}) & m;
        half = longint'(1) << (w - 1);
        dz   = 1'b0;
        ov   = 1'b0;
        if (ru == 0) begin
            q  = 32'(m);
            rm = 32'(lu);
            dz = 1'b1;
        end else if (s) begin
            lv = (lu >= half) ? lu - (longint'(1) << w) : lu;
            rv = (ru >= half) ? ru - (longint'(1) << w) : ru;
            if (lv == -half && rv == -1) begin
                q  = 32'(lu);
                rm = 32'd0;
                ov = 1'b1;
            end else begin
                qq = lv / rv;
                rr = lv % rv;
                q  = 32'(qq & m);
                rm = 32'(rr & m);
            end
        end else begin
            q  = 32'(lu / ru);
            rm = 32'(lu % ru);
        end
    endfunction

    always @(negedge clk) begin
        logic [63:0] m64, ident;
        for (int i = 0; i < 3; i++) begin
            if (done_v[i]) begin
                if (!pend[i]) begin
                    chk($sformatf("unexpected_done%0d", i), 32'd1, 32'd0);
                end else begin
                    m64 = mask_of(widths[i]);
                    chk($sformatf("latency%0d", i), cyc, exp_cyc[i]);
                    chk($sformatf("quotient%0d", i), q_a[i], exp_q[i]);
                    chk($sformatf("remainder%0d", i), rm_a[i], exp_rm[i]);
                    chk($sformatf("div_by_zero%0d", i), {31'b0, dz_v[i]}, {31'b0, exp_dz[i]});
                    chk($sformatf("overflow%0d", i), {31'b0, ov_v[i]}, {31'b0, exp_ov[i]});
                    if (!exp_dz[i]) begin
                        ident = ({32'b0, q_a[i]} * ({32'b0, exp_r[i]} & m64) + {32'b0, rm_a[i]}) & m64;
                        chk($sformatf("identity%0d", i), ident[31:0], exp_l[i] & m64[31:0]);
                    end
                    last_q[i]  = q_a[i];
                    last_rm[i] = rm_a[i];
                    last_dz[i] = dz_v[i];
                    last_ov[i] = ov_v[i];
                    pend[i]    = 1'b0;
                end
            end else begin
                chk($sformatf("flags_idle%0d", i), {30'b0, dz_v[i], ov_v[i]}, 32'd0);
                if (pend[i] && cyc > exp_cyc[i]) begin
                    chk($sformatf("late_done%0d", i), cyc, exp_cyc[i]);
                    pend[i] = 1'b0;
                end
            end
        end
    end

    task automatic start_op(input int i, input logic [31:0] l, input logic [31:0] r);
        logic [31:0] q, rm;
        logic dz, ov;
        go_v[i] = 1'b1;
        l_a[i]  = l;
        r_a[i]  = r;
        model(widths[i], sgn[i], l, r, q, rm, dz, ov);
        exp_q[i]   = q;
        exp_rm[i]  = rm;
        exp_dz[i]  = dz;
        exp_ov[i]  = ov;
        exp_l[i]   = l;
        exp_r[i]   = r;
        exp_cyc[i] = cyc + (dz ? 2 : widths[i] + 2);
        pend[i]    = 1'b1;
    endtask

    task automatic wait_done(input int i);
        int n = 0;
        while (pend[i] && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (pend[i]) begin
            chk($sformatf("timeout%0d", i), 32'd0, 32'd1);
            pend[i] = 1'b0;
        end
    endtask

    task automatic op(input int i, input logic [31:0] l, input logic [31:0] r);
        start_op(i, l, r);
        wait_done(i);
        go_v[i] = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] l, r, mn;
        int k;
        go_v = '0;
        for (int i = 0; i < 3; i++) begin
            l_a[i] = '0;
            r_a[i] = '0;
            pend[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_q%0d", i), q_a[i], 32'd0);
            chk($sformatf("rst_rm%0d", i), rm_a[i], 32'd0);
            chk($sformatf("rst_flags%0d", i), {29'b0, done_v[i], dz_v[i], ov_v[i]}, 32'd0);
        end
        reset = 1'b0;
        #1;

        op(0, 32'd200, 32'd7);
        chk("lit_u_200_7_q", last_q[0], 32'd28);
        chk("lit_u_200_7_r", last_rm[0], 32'd4);

        op(1, 32'hF9, 32'd2);
        chk("lit_s_m7_2_q", last_q[1], 32'hFD);
        chk("lit_s_m7_2_r", last_rm[1], 32'hFF);
        op(1, 32'd7, 32'hFE);
        chk("lit_s_7_m2_q", last_q[1], 32'hFD);
        chk("lit_s_7_m2_r", last_rm[1], 32'h01);
        op(1, 32'hF9, 32'hFE);
        chk("lit_s_m7_m2_q", last_q[1], 32'h03);
        chk("lit_s_m7_m2_r", last_rm[1], 32'hFF);

        op(2, 32'h1234, 32'd0);
        chk("lit_dz_q", last_q[2], 32'hFFFF_FFFF);
        chk("lit_dz_r", last_rm[2], 32'h1234);
        chk("lit_dz_flag", {31'b0, last_dz[2]}, 32'd1);

        op(1, 32'h80, 32'hFF);
        chk("lit_ovf_q", last_q[1], 32'h80);
        chk("lit_ovf_r", last_rm[1], 32'h00);
        chk("lit_ovf_flag", {31'b0, last_ov[1]}, 32'd1);
        op(0, 32'h80, 32'hFF);
        chk("lit_u80_q", last_q[0], 32'h00);
        chk("lit_u80_r", last_rm[0], 32'h80);
        chk("lit_u80_ovf", {31'b0, last_ov[0]}, 32'd0);

        // abort: drop go part-way through RUN, no done may follow
        go_v[0] = 1'b1;
        l_a[0]  = 32'd50;
        r_a[0]  = 32'd3;
        repeat (5) @(negedge clk);
        #1;
        go_v[0] = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        chk("abort_hold_q", q_a[0], 32'h00);
        chk("abort_hold_r", rm_a[0], 32'h80);
        op(0, 32'd100, 32'd9);
        chk("lit_100_9_q", last_q[0], 32'd11);
        chk("lit_100_9_r", last_rm[0], 32'd1);

        // reset mid-RUN
        start_op(0, 32'd200, 32'd7);
        repeat (4) @(negedge clk);
        #1;
        pend[0] = 1'b0;
        go_v[0] = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("midrst_q", q_a[0], 32'd0);
        chk("midrst_r", rm_a[0], 32'd0);
        chk("midrst_flags", {29'b0, done_v[0], dz_v[0], ov_v[0]}, 32'd0);
        reset = 1'b0;
        #1;
        op(0, 32'd250, 32'd16);
        chk("post_rst_q", last_q[0], 32'd15);
        chk("post_rst_r", last_rm[0], 32'd10);

        // back-to-back: go held through done starts a new operation
        start_op(1, 32'h9C, 32'd7);
        wait_done(1);
        chk("b2b_first_q", last_q[1], 32'hF2);
        chk("b2b_first_r", last_rm[1], 32'hFE);
        start_op(1, 32'd100, 32'hF9);
        wait_done(1);
        go_v[1] = 1'b0;
        chk("b2b_second_q", last_q[1], 32'hF2);
        chk("b2b_second_r", last_rm[1], 32'h02);
        @(negedge clk);
        #1;

        for (int i = 0; i < 3; i++) begin
            mn = 32'd1 << (widths[i] - 1);
            for (int n = 0; n < ((i == 2) ? 300 : 2000); n++) begin
                l = $urandom;
                r = $urandom;
                k = $urandom_range(0, 9);
                if (k == 0) r = 32'd0;
                if (k == 1) r = '1;
                if (k == 1 || k == 2) l = mn;
                if (k == 3) r = $urandom_range(1, 3);
                op(i, l, r);
            end
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
